// File: rtl/data_mem_server_pkg.sv
// Shared types for the gpu data-memory server: channel FSM states, operation kind
// and the width of the per-channel latency counter.
package data_mem_server_pkg;

  localparam int LAT_BITS = 4;

  typedef enum logic [2:0] {
    IDLE,
    PENDING,
    ACCESS,
    RESP,
    DONE
  } ch_state_e;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr (wrapping) and
// reports the pointer that follows the granted channel. Purely combinational.
module rr_arbiter #(
  parameter int NUM_CHANNELS = 4,
  parameter int PTR_BITS     = 2
) (
  input  logic [NUM_CHANNELS-1:0] req,
  input  logic                    enable,
  input  logic [PTR_BITS-1:0]     ptr,
  output logic [NUM_CHANNELS-1:0] grant,
  output logic [PTR_BITS-1:0]     next_ptr
);

  int best;

  // Distance of channel j from the pointer in search order.
  function automatic int rr_dist(input int j, input logic [PTR_BITS-1:0] p);
    return (j + NUM_CHANNELS - int'(p)) % NUM_CHANNELS;
  endfunction

  // NOTE: every output of a combinational block gets a default before any branch,
  // otherwise the unassigned paths infer latches.
  always_comb begin
    best     = NUM_CHANNELS;
    grant    = '0;
    next_ptr = ptr;
    for (int j = 0; j < NUM_CHANNELS; j++) begin
      if (req[j] && rr_dist(j, ptr) < best) best = rr_dist(j, ptr);
    end
    for (int j = 0; j < NUM_CHANNELS; j++) begin
      if (enable && req[j] && rr_dist(j, ptr) == best) begin
        grant[j] = 1'b1;
        next_ptr = PTR_BITS'((j + 1) % NUM_CHANNELS);
      end
    end
  end

endmodule

// File: rtl/data_mem_server.sv
// Data memory behind the gpu data-memory controller: NUM_CHANNELS valid/ready
// channels share one array via round-robin grants with a fixed LATENCY, plus a host port.
module data_mem_server
  import data_mem_server_pkg::*;
#(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int LATENCY      = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  host_write_enable,
  input  logic [ADDR_BITS-1:0]                  host_write_address,
  input  logic [DATA_BITS-1:0]                  host_write_data,
  input  logic [ADDR_BITS-1:0]                  host_read_address,
  output logic [DATA_BITS-1:0]                  host_read_data,
  input  logic [NUM_CHANNELS-1:0]               mem_read_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address,
  output logic [NUM_CHANNELS-1:0]               mem_read_ready,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data,
  input  logic [NUM_CHANNELS-1:0]               mem_write_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data,
  output logic [NUM_CHANNELS-1:0]               mem_write_ready,
  output logic                                  busy
);

  localparam int                  PTR_BITS = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [LAT_BITS-1:0] LAT_INIT = LAT_BITS'(LATENCY - 1);

  logic [DATA_BITS-1:0]    mem [2**ADDR_BITS];
  logic [NUM_CHANNELS-1:0] req, grant, is_write, is_idle;
  logic [PTR_BITS-1:0]     rr_ptr, rr_ptr_next;
  logic                    ch_we;
  logic [ADDR_BITS-1:0]    ch_waddr;
  logic [DATA_BITS-1:0]    ch_wdata;

  // A host write owns the array for that cycle, so no channel is granted.
  rr_arbiter #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .PTR_BITS     (PTR_BITS)
  ) u_arb (
    .req      (req),
    .enable   (!host_write_enable),
    .ptr      (rr_ptr),
    .grant    (grant),
    .next_ptr (rr_ptr_next)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_ptr <= '0;
    else        rr_ptr <= rr_ptr_next;
  end

  always_comb begin
    ch_we    = 1'b0;
    ch_waddr = '0;
    ch_wdata = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (grant[c] && is_write[c]) begin
        ch_we    = 1'b1;
        ch_waddr = mem_write_address[c];
        ch_wdata = mem_write_data[c];
      end
    end
  end

  // NOTE: the array itself is never reset; contents survive reset and are
  // preloaded by the host, which also keeps it mappable onto RAM macros.
  always_ff @(posedge clk) begin
    if (host_write_enable) mem[host_write_address] <= host_write_data;
    else if (ch_we)        mem[ch_waddr]           <= ch_wdata;
  end

  // Read-before-write: a same-cycle host write to this address shows up next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) host_read_data <= '0;
    else        host_read_data <= mem[host_read_address];
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    ch_state_e            state_q, state_d;
    op_e                  op_q, op_d;
    logic [LAT_BITS-1:0]  cnt_q, cnt_d;
    logic [DATA_BITS-1:0] rdata_q;
    logic                 served_valid;

    assign served_valid = (op_q == OP_WRITE) ? mem_write_valid[c] : mem_read_valid[c];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= IDLE;
        op_q    <= OP_READ;
        cnt_q   <= '0;
        rdata_q <= '0;
      end else begin
        state_q <= state_d;
        op_q    <= op_d;
        cnt_q   <= cnt_d;
        if (grant[c] && op_q == OP_READ) rdata_q <= mem[mem_read_address[c]];
      end
    end

    // Writes win over a simultaneous read; the read is picked up from IDLE afterwards.
    always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      unique case (state_q)
        IDLE: begin
          if (mem_write_valid[c]) begin
            state_d = PENDING;
            op_d    = OP_WRITE;
          end else if (mem_read_valid[c]) begin
            state_d = PENDING;
            op_d    = OP_READ;
          end
        end
        PENDING: begin
          if (grant[c]) begin
            cnt_d   = LAT_INIT;
            state_d = (LATENCY == 1) ? RESP : ACCESS;
          end
        end
        ACCESS: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q <= LAT_BITS'(1)) state_d = RESP;
        end
        RESP:    state_d = DONE;
        DONE:    if (!served_valid) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    assign req[c]             = (state_q == PENDING);
    assign is_write[c]        = (op_q == OP_WRITE);
    assign is_idle[c]         = (state_q == IDLE);
    assign mem_read_ready[c]  = (state_q == RESP) && (op_q == OP_READ);
    assign mem_write_ready[c] = (state_q == RESP) && (op_q == OP_WRITE);
    assign mem_read_data[c]   = rdata_q;
  end

  assign busy = ~&is_idle;

endmodule

// File: tb/tb_data_mem_server.sv
// Scoreboard bench for data_mem_server: requesters push expected responses,
// a negedge monitor matches every ready pulse against the queue.
module tb_data_mem_server;

  localparam int NCH = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                host_write_enable;
  logic [7:0]          host_write_address, host_write_data, host_read_address;
  logic [7:0]          host_read_data;
  logic [NCH-1:0]      mem_read_valid, mem_read_ready;
  logic [NCH-1:0][7:0] mem_read_address, mem_read_data;
  logic [NCH-1:0]      mem_write_valid, mem_write_ready;
  logic [NCH-1:0][7:0] mem_write_address, mem_write_data;
  logic                busy;

  typedef struct {
    int         ch;
    bit         wr;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  data_mem_server dut (
    .clk                (clk),
    .reset              (reset),
    .host_write_enable  (host_write_enable),
    .host_write_address (host_write_address),
    .host_write_data    (host_write_data),
    .host_read_address  (host_read_address),
    .host_read_data     (host_read_data),
    .mem_read_valid     (mem_read_valid),
    .mem_read_address   (mem_read_address),
    .mem_read_ready     (mem_read_ready),
    .mem_read_data      (mem_read_data),
    .mem_write_valid    (mem_write_valid),
    .mem_write_address  (mem_write_address),
    .mem_write_data     (mem_write_data),
    .mem_write_ready    (mem_write_ready),
    .busy               (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic match_resp(input int ch, input bit wr, input logic [7:0] data);
    int idx = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (idx < 0 && exp_q[i].ch == ch && exp_q[i].wr == wr) idx = i;
    if (idx < 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_ready: ch%0d wr=%0d at cycle %0d, none expected", ch, wr, cyc);
    end else begin
      check($sformatf("ready_cycle_ch%0d", ch), cyc, exp_q[idx].cyc);
      if (!wr) check($sformatf("read_data_ch%0d", ch), data, exp_q[idx].data);
      exp_q.delete(idx);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        if (mem_read_ready[c])  match_resp(c, 1'b0, mem_read_data[c]);
        if (mem_write_ready[c]) match_resp(c, 1'b1, 8'h00);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    repeat (3) step();
  endtask

  task automatic host_write(input logic [7:0] addr, input logic [7:0] data);
    host_write_enable  = 1'b1;
    host_write_address = addr;
    host_write_data    = data;
    step();
    host_write_enable  = 1'b0;
  endtask

  // Issue one request, expect its ready lat cycles after the valid rises,
  // optionally hold valid for extra cycles to prove it is not re-served.
  task automatic do_req(input int ch, input bit wr, input logic [7:0] addr,
                        input logic [7:0] wdata, input int lat,
                        input logic [7:0] exp_data, input int hold);
    bit got = 1'b0;
    exp_q.push_back('{ch, wr, exp_data, cyc + lat});
    if (wr) begin
      mem_write_address[ch] = addr;
      mem_write_data[ch]    = wdata;
      mem_write_valid[ch]   = 1'b1;
    end else begin
      mem_read_address[ch]  = addr;
      mem_read_valid[ch]    = 1'b1;
    end
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge clk);
      got = wr ? mem_write_ready[ch] : mem_read_ready[ch];
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL timeout_ch%0d: no ready within 64 cycles", ch);
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check($sformatf("single_pulse_ch%0d", ch), mem_read_ready[ch] | mem_write_ready[ch], 0);
    end
    if (wr) mem_write_valid[ch] = 1'b0;
    else    mem_read_valid[ch]  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset              = 1'b0;
    host_write_enable  = 1'b0;
    host_write_address = '0;
    host_write_data    = '0;
    host_read_address  = '0;
    mem_read_valid     = '0;
    mem_read_address   = '0;
    mem_write_valid    = '0;
    mem_write_address  = '0;
    mem_write_data     = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_read_ready", mem_read_ready, 0);
    check("reset_write_ready", mem_write_ready, 0);
    check("reset_read_data", mem_read_data, 0);
    check("reset_host_read_data", host_read_data, 0);
    reset = 1'b1;
    step();

    // Preload through the host port.
    host_write(8'h00, 8'h11);
    host_write(8'h01, 8'h12);
    host_write(8'h02, 8'h13);
    host_write(8'h03, 8'h14);
    host_write(8'h10, 8'h5A);
    gap();

    // All four channels at once from pointer 0: grants 0,1,2,3 on consecutive cycles.
    fork
      do_req(0, 1'b0, 8'h00, 8'h00, 3, 8'h11, 0);
      do_req(1, 1'b0, 8'h01, 8'h00, 4, 8'h12, 0);
      do_req(2, 1'b0, 8'h02, 8'h00, 5, 8'h13, 0);
      do_req(3, 1'b0, 8'h03, 8'h00, 6, 8'h14, 0);
    join
    gap();

    // Single read of preloaded data; valid held one extra cycle after ready.
    do_req(0, 1'b0, 8'h10, 8'h00, 3, 8'h5A, 1);
    gap();
    check("read_data_held_ch0", mem_read_data[0], 8'h5A);
    check("idle_after_done", busy, 0);

    // Channel write then another channel reads it back, then the host port.
    do_req(1, 1'b1, 8'h20, 8'hC3, 3, 8'h00, 0);
    step();
    do_req(2, 1'b0, 8'h20, 8'h00, 3, 8'hC3, 0);
    host_read_address = 8'h20;
    step();
    check("host_read_after_ch_write", host_read_data, 8'hC3);
    gap();

    // Pointer now 3: channel 3 wins over 0, pointer wraps to 1.
    fork
      do_req(0, 1'b0, 8'h00, 8'h00, 4, 8'h11, 0);
      do_req(3, 1'b0, 8'h03, 8'h00, 3, 8'h14, 0);
    join
    gap();
    check("read_data_held_ch3", mem_read_data[3], 8'h14);
    // Pointer at 1: channel 1 wins over 0.
    fork
      do_req(0, 1'b0, 8'h01, 8'h00, 4, 8'h12, 0);
      do_req(1, 1'b0, 8'h02, 8'h00, 3, 8'h13, 0);
    join
    gap();

    // Host write held three cycles while channel 0 is pending: ready 3 cycles late.
    fork
      do_req(0, 1'b0, 8'h10, 8'h00, 6, 8'h5A, 0);
      begin
        step();
        host_write_enable  = 1'b1;
        host_write_address = 8'h40;
        host_write_data    = 8'h01;
        repeat (3) step();
        host_write_enable  = 1'b0;
      end
    join
    gap();

    // Same-cycle host write and read of one address returns the old value.
    host_read_address  = 8'h20;
    host_write_enable  = 1'b1;
    host_write_address = 8'h20;
    host_write_data    = 8'h99;
    step();
    host_write_enable  = 1'b0;
    check("host_rw_same_cycle_old", host_read_data, 8'hC3);
    step();
    check("host_rw_next_cycle_new", host_read_data, 8'h99);
    gap();

    // Asynchronous reset while a channel 0 read is in ACCESS.
    mem_read_address[0] = 8'h10;
    mem_read_valid[0]   = 1'b1;
    step();
    step();
    check("busy_in_flight", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("busy_async_reset", busy, 0);
    check("ready_async_reset", mem_read_ready, 0);
    check("read_data_async_reset", mem_read_data[0], 8'h00);
    check("host_read_async_reset", host_read_data, 8'h00);
    mem_read_valid[0] = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    check("array_persists_reset", host_read_data, 8'h99);
    gap();
    do_req(0, 1'b0, 8'h10, 8'h00, 3, 8'h5A, 0);
    gap();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
